// File: rtl/xdivider.sv
// Memory-mapped restoring divider, one quotient bit per clock, results readable over the peripheral bus.
// Define XDIVIDER_SIGNED_EN to treat operands as two's complement (truncating toward zero).
module xdivider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             divsel,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] number,
    output logic [31:0]      data_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(WIDTH);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
`ifdef XDIVIDER_SIGNED_EN
        return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] negate_if(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] dividend_q,  dividend_d;
    logic [WIDTH-1:0] divisor_q,   divisor_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [WIDTH-1:0] work_q,      work_d;
    logic [WIDTH-1:0] part_q,      part_d;
    logic [CW-1:0]    count_q,     count_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             div0_q,      div0_d;
`ifdef XDIVIDER_SIGNED_EN
    logic             neg_quo_q,   neg_quo_d;
    logic             neg_rem_q,   neg_rem_d;
`endif

    logic             wr_dividend_s;
    logic             wr_divisor_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic             ge_s;
    logic [WIDTH-1:0] part_nx_s;
    logic [WIDTH-1:0] work_nx_s;

    assign wr_dividend_s = divsel && (addr == 3'd0);
    assign wr_divisor_s  = divsel && (addr == 3'd1);

    // Restoring step: the borrow of (shifted - divisor) decides the quotient bit, since the
    // partial remainder always stays below the divisor.
    assign shifted_s = {part_q, work_q[WIDTH-1]};
    assign diff_s    = shifted_s - {1'b0, divisor_q};
    assign ge_s      = ~diff_s[WIDTH];
    assign part_nx_s = ge_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
    assign work_nx_s = {work_q[WIDTH-2:0], ge_s};

    // Next-state and register update logic for the bus registers and the divide FSM.
    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        work_d      = work_q;
        part_d      = part_q;
        count_d     = count_q;
        busy_d      = busy_q;
        done_d      = done_q;
        div0_d      = div0_q;
`ifdef XDIVIDER_SIGNED_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (wr_dividend_s) begin
                    dividend_d = number;
                end else if (wr_divisor_s) begin
                    divisor_d = magnitude(number);
                    if (number != ZERO_W) begin
                        work_d  = magnitude(dividend_q);
                        part_d  = ZERO_W;
                        count_d = CNT_FULL;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        div0_d  = 1'b0;
                        state_d = RUN;
`ifdef XDIVIDER_SIGNED_EN
                        neg_quo_d = dividend_q[WIDTH-1] ^ number[WIDTH-1];
                        neg_rem_d = dividend_q[WIDTH-1];
`endif
                    end else begin
                        // Divide by zero completes on the start edge without entering RUN.
`ifdef XDIVIDER_SIGNED_EN
                        quotient_d = dividend_q[WIDTH-1] ? {{(WIDTH-1){1'b0}}, 1'b1} : ONES_W;
`else
                        quotient_d = ONES_W;
`endif
                        remainder_d = dividend_q;
                        div0_d      = 1'b1;
                        done_d      = 1'b1;
                    end
                end else begin
                    dividend_d = dividend_q;
                end
            end
            RUN: begin
                work_d  = work_nx_s;
                part_d  = part_nx_s;
                count_d = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
`ifdef XDIVIDER_SIGNED_EN
                    quotient_d  = negate_if(neg_quo_q, work_nx_s);
                    remainder_d = negate_if(neg_rem_q, part_nx_s);
`else
                    quotient_d  = work_nx_s;
                    remainder_d = part_nx_s;
`endif
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any run and clears every result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            dividend_q  <= ZERO_W;
            divisor_q   <= ZERO_W;
            quotient_q  <= ZERO_W;
            remainder_q <= ZERO_W;
            work_q      <= ZERO_W;
            part_q      <= ZERO_W;
            count_q     <= {CW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div0_q      <= 1'b0;
`ifdef XDIVIDER_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            work_q      <= work_d;
            part_q      <= part_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div0_q      <= div0_d;
`ifdef XDIVIDER_SIGNED_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    // Read mux; write-only and unmapped addresses read as zero.
    always_comb begin
        case (addr)
            3'd2:    data_out = 32'(quotient_q);
            3'd3:    data_out = 32'(remainder_q);
            3'd4:    data_out = {29'd0, div0_q, done_q, busy_q};
            default: data_out = 32'd0;
        endcase
    end

endmodule
